// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS controller: FSM states,
// opcodes, ALU function codes, access sizes and the decoded control word.
package mips_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] ALU_ADD  = 6'h20;
    localparam logic [5:0] ALU_ADDU = 6'h21;
    localparam logic [5:0] ALU_AND  = 6'h24;
    localparam logic [5:0] ALU_OR   = 6'h25;
    localparam logic [5:0] ALU_XOR  = 6'h26;
    localparam logic [5:0] ALU_SLT  = 6'h2A;
    localparam logic [5:0] ALU_BEQ  = 6'h30;
    localparam logic [5:0] ALU_BNE  = 6'h31;
    localparam logic [5:0] ALU_J    = 6'h32;
    localparam logic [5:0] ALU_LUI  = 6'h3F;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b11;

    typedef struct packed {
        logic       rtype;
        logic       is_load;
        logic       is_store;
        logic       is_branch;
        logic       alu_src_imm;
        logic [5:0] alu_func;
        logic [1:0] mem_size;
    } ctrl_word_t;

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Controller <-> datapath bundle. master = controller, slave = datapath.
// CTRL_PERF_COUNTERS_EN adds the instruction and stall counter outputs.
interface mips_multicycle_ctrl_if #(
    parameter int DATA_SIZE_W = 2
);
    logic [5:0]             opcode_in;
    logic [5:0]             func_in;
    logic                   alu_branch_in;
    logic                   alu_jump_in;
    logic                   mem_wait_in;
    logic                   pc_en_out;
    logic                   inst_mux_sel_out;
    logic                   regfile_we_out;
    logic                   alu_mux_sel_out;
    logic [5:0]             alu_func_out;
    logic                   data_mem_re_out;
    logic                   data_mem_we_out;
    logic [DATA_SIZE_W-1:0] data_mem_size_out;
    logic                   data_mem_mux_sel_out;
    logic                   branch_taken_out;
    logic                   illegal_op_out;
`ifdef CTRL_PERF_COUNTERS_EN
    logic [31:0]            instr_count_out;
    logic [31:0]            stall_count_out;
`endif

    modport master (
        input  opcode_in, func_in, alu_branch_in, alu_jump_in, mem_wait_in,
        output pc_en_out, inst_mux_sel_out, regfile_we_out, alu_mux_sel_out,
        output alu_func_out, data_mem_re_out, data_mem_we_out, data_mem_size_out,
        output data_mem_mux_sel_out, branch_taken_out, illegal_op_out
`ifdef CTRL_PERF_COUNTERS_EN
        , output instr_count_out, stall_count_out
`endif
    );

    modport slave (
        output opcode_in, func_in, alu_branch_in, alu_jump_in, mem_wait_in,
        input  pc_en_out, inst_mux_sel_out, regfile_we_out, alu_mux_sel_out,
        input  alu_func_out, data_mem_re_out, data_mem_we_out, data_mem_size_out,
        input  data_mem_mux_sel_out, branch_taken_out, illegal_op_out
`ifdef CTRL_PERF_COUNTERS_EN
        , input instr_count_out, stall_count_out
`endif
    );

endinterface

// File: rtl/mips_ctrl_decode.sv
// Combinational opcode/funct decode into the controller's control word.
module mips_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output ctrl_word_t cw,
    output logic       illegal
);

    always_comb begin
        cw      = '0;
        illegal = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                cw.rtype    = 1'b1;
                cw.alu_func = funct;
                illegal     = !(funct inside {[6'h20:6'h27], 6'h2A, 6'h2B,
                                              6'h00, 6'h02, 6'h03});
            end
            OP_ADDI:  begin cw.alu_src_imm = 1'b1; cw.alu_func = ALU_ADD;  end
            OP_ADDIU: begin cw.alu_src_imm = 1'b1; cw.alu_func = ALU_ADDU; end
            OP_SLTI:  begin cw.alu_src_imm = 1'b1; cw.alu_func = ALU_SLT;  end
            OP_ANDI:  begin cw.alu_src_imm = 1'b1; cw.alu_func = ALU_AND;  end
            OP_ORI:   begin cw.alu_src_imm = 1'b1; cw.alu_func = ALU_OR;   end
            OP_XORI:  begin cw.alu_src_imm = 1'b1; cw.alu_func = ALU_XOR;  end
            OP_LUI:   begin cw.alu_src_imm = 1'b1; cw.alu_func = ALU_LUI;  end
            OP_LB, OP_LH, OP_LW: begin
                cw.is_load     = 1'b1;
                cw.alu_src_imm = 1'b1;
                cw.alu_func    = ALU_ADDU;
                cw.mem_size    = (opcode == OP_LB) ? SIZE_BYTE :
                                 (opcode == OP_LH) ? SIZE_HALF : SIZE_WORD;
            end
            OP_SB, OP_SH, OP_SW: begin
                cw.is_store    = 1'b1;
                cw.alu_src_imm = 1'b1;
                cw.alu_func    = ALU_ADDU;
                cw.mem_size    = (opcode == OP_SB) ? SIZE_BYTE :
                                 (opcode == OP_SH) ? SIZE_HALF : SIZE_WORD;
            end
            OP_BEQ:   begin cw.is_branch = 1'b1; cw.alu_func = ALU_BEQ; end
            OP_BNE:   begin cw.is_branch = 1'b1; cw.alu_func = ALU_BNE; end
            OP_J:     begin cw.is_branch = 1'b1; cw.alu_func = ALU_J;   end
            default:  illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM; one instruction in flight, MEM stalls on mem_wait_in.
// Optional CTRL_PERF_COUNTERS_EN adds instruction/stall counters.
//
// state     | meaning
// ST_FETCH  | instruction ROM read, held FETCH_CYCLES cycles
// ST_DECODE | opcode/funct captured into cw_q
// ST_EXEC   | ALU operation; branches, jumps and illegal ops retire here
// ST_MEM    | data access, held while mem_wait_in = 1; stores retire on exit
// ST_WB     | register-file write and PC advance
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int FETCH_CYCLES = 1,
    parameter int DATA_SIZE_W  = 2
) (
    input logic                    clock,
    input logic                    reset,
    mips_multicycle_ctrl_if.master bus
);

    localparam logic [1:0] FETCH_LAST = 2'(FETCH_CYCLES - 1);

    state_e     state;
    logic [1:0] fetch_cnt;
    ctrl_word_t cw_dec;
    ctrl_word_t cw_q;
    logic       illegal_dec;
    logic       ill_q;
    logic       pc_en_q;
    logic       regfile_we_q;
    logic       inst_mux_q;
    logic       re_q;
    logic       we_q;
    logic       dmux_q;
    logic       taken_q;
    logic       illegal_q;
    logic [1:0] size_q;
    logic       pc_en;

    mips_ctrl_decode u_decode (
        .opcode  (bus.opcode_in),
        .funct   (bus.func_in),
        .cw      (cw_dec),
        .illegal (illegal_dec)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= ST_FETCH;
            fetch_cnt    <= '0;
            cw_q         <= '0;
            ill_q        <= 1'b0;
            pc_en_q      <= 1'b0;
            regfile_we_q <= 1'b0;
            inst_mux_q   <= 1'b0;
            re_q         <= 1'b0;
            we_q         <= 1'b0;
            size_q       <= SIZE_BYTE;
            dmux_q       <= 1'b0;
            taken_q      <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            pc_en_q      <= 1'b0;
            regfile_we_q <= 1'b0;
            inst_mux_q   <= 1'b0;
            dmux_q       <= 1'b0;
            case (state)
                ST_FETCH: begin
                    if (fetch_cnt == FETCH_LAST) begin
                        fetch_cnt <= '0;
                        state     <= ST_DECODE;
                    end else begin
                        fetch_cnt <= fetch_cnt + 2'd1;
                    end
                end
                ST_DECODE: begin
                    state <= ST_EXEC;
                    ill_q <= illegal_dec;
                    // Illegal ops run as a NOP with a blank control word.
                    if (illegal_dec) begin
                        cw_q      <= '0;
                        illegal_q <= 1'b1;
                        pc_en_q   <= 1'b1;
                    end else begin
                        cw_q    <= cw_dec;
                        pc_en_q <= cw_dec.is_branch;
                    end
                end
                ST_EXEC: begin
                    if (ill_q || cw_q.is_branch) begin
                        state <= ST_FETCH;
                        cw_q  <= '0;
                        ill_q <= 1'b0;
                        if (cw_q.is_branch) begin
                            taken_q <= bus.alu_branch_in | bus.alu_jump_in;
                        end
                    end else if (cw_q.is_load || cw_q.is_store) begin
                        state  <= ST_MEM;
                        re_q   <= cw_q.is_load;
                        we_q   <= cw_q.is_store;
                        size_q <= cw_q.mem_size;
                    end else begin
                        state        <= ST_WB;
                        regfile_we_q <= 1'b1;
                        pc_en_q      <= 1'b1;
                        inst_mux_q   <= cw_q.rtype;
                    end
                end
                ST_MEM: begin
                    if (!bus.mem_wait_in) begin
                        re_q   <= 1'b0;
                        we_q   <= 1'b0;
                        size_q <= SIZE_BYTE;
                        if (cw_q.is_load) begin
                            state        <= ST_WB;
                            regfile_we_q <= 1'b1;
                            pc_en_q      <= 1'b1;
                            dmux_q       <= 1'b1;
                        end else begin
                            state <= ST_FETCH;
                            cw_q  <= '0;
                        end
                    end
                end
                ST_WB: begin
                    state <= ST_FETCH;
                    cw_q  <= '0;
                end
                default: begin
                    state <= ST_FETCH;
                    cw_q  <= '0;
                end
            endcase
        end
    end

    // A store retires in the very cycle the memory drops its wait.
    assign pc_en = pc_en_q | (we_q & ~bus.mem_wait_in);

    assign bus.pc_en_out            = pc_en;
    assign bus.inst_mux_sel_out     = inst_mux_q;
    assign bus.regfile_we_out       = regfile_we_q;
    assign bus.alu_mux_sel_out      = cw_q.alu_src_imm;
    assign bus.alu_func_out         = cw_q.alu_func;
    assign bus.data_mem_re_out      = re_q;
    assign bus.data_mem_we_out      = we_q;
    assign bus.data_mem_size_out    = DATA_SIZE_W'(size_q);
    assign bus.data_mem_mux_sel_out = dmux_q;
    assign bus.branch_taken_out     = taken_q;
    assign bus.illegal_op_out       = illegal_q;

`ifdef CTRL_PERF_COUNTERS_EN
    logic [31:0] instr_cnt;
    logic [31:0] stall_cnt;

    always_ff @(posedge clock) begin
        if (!reset) begin
            instr_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (pc_en) begin
                instr_cnt <= instr_cnt + 32'd1;
            end
            if (state == ST_MEM && bus.mem_wait_in) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end

    assign bus.instr_count_out = instr_cnt;
    assign bus.stall_count_out = stall_cnt;
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized bench for mips_multicycle_ctrl against a per-instruction timing model.
module tb_mips_multicycle_ctrl;

    localparam int FC  = 1;
    localparam int DSW = 2;

    localparam int K_ILL = 0;
    localparam int K_R   = 1;
    localparam int K_IMM = 2;
    localparam int K_LD  = 3;
    localparam int K_ST  = 4;
    localparam int K_BR  = 5;

    logic clock = 1'b0;
    logic reset = 1'b0;

    mips_multicycle_ctrl_if #(.DATA_SIZE_W(DSW)) bus ();

    mips_multicycle_ctrl #(.FETCH_CYCLES(FC), .DATA_SIZE_W(DSW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int         checks   = 0;
    int         failures = 0;
    int         kind_tab [64];
    logic [5:0] func_tab [64];
    logic [1:0] size_tab [64];
    bit         rfn_ok   [64];
    logic [5:0] legal_ops [16];
    logic       m_taken;
    logic       m_ill;
    int         m_instr;
    int         m_stall;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_op(input int op, input int k, input logic [5:0] f, input logic [1:0] s);
        kind_tab[op] = k;
        func_tab[op] = f;
        size_tab[op] = s;
    endtask

    task automatic init_tables();
        for (int i = 0; i < 64; i++) begin
            kind_tab[i] = K_ILL;
            func_tab[i] = 6'h00;
            size_tab[i] = 2'b00;
            rfn_ok[i]   = 1'b0;
        end
        kind_tab[0] = K_R;
        set_op(8'h08, K_IMM, 6'h20, 2'b00);
        set_op(8'h09, K_IMM, 6'h21, 2'b00);
        set_op(8'h0A, K_IMM, 6'h2A, 2'b00);
        set_op(8'h0C, K_IMM, 6'h24, 2'b00);
        set_op(8'h0D, K_IMM, 6'h25, 2'b00);
        set_op(8'h0E, K_IMM, 6'h26, 2'b00);
        set_op(8'h0F, K_IMM, 6'h3F, 2'b00);
        set_op(8'h20, K_LD,  6'h21, 2'b00);
        set_op(8'h21, K_LD,  6'h21, 2'b01);
        set_op(8'h23, K_LD,  6'h21, 2'b11);
        set_op(8'h28, K_ST,  6'h21, 2'b00);
        set_op(8'h29, K_ST,  6'h21, 2'b01);
        set_op(8'h2B, K_ST,  6'h21, 2'b11);
        set_op(8'h04, K_BR,  6'h30, 2'b00);
        set_op(8'h05, K_BR,  6'h31, 2'b00);
        set_op(8'h02, K_BR,  6'h32, 2'b00);
        for (int f = 8'h20; f <= 8'h27; f++) rfn_ok[f] = 1'b1;
        rfn_ok[8'h2A] = 1'b1;
        rfn_ok[8'h2B] = 1'b1;
        rfn_ok[8'h00] = 1'b1;
        rfn_ok[8'h02] = 1'b1;
        rfn_ok[8'h03] = 1'b1;
        legal_ops = '{6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0C,
                      6'h0D, 6'h0E, 6'h0F, 6'h20, 6'h21, 6'h23, 6'h28, 6'h2B};
    endtask

    task automatic check_idle(input string tag);
        check_val({tag, "_pc_en"},    {31'd0, bus.pc_en_out},            32'd0);
        check_val({tag, "_rf_we"},    {31'd0, bus.regfile_we_out},       32'd0);
        check_val({tag, "_re"},       {31'd0, bus.data_mem_re_out},      32'd0);
        check_val({tag, "_we"},       {31'd0, bus.data_mem_we_out},      32'd0);
        check_val({tag, "_inst_mux"}, {31'd0, bus.inst_mux_sel_out},     32'd0);
        check_val({tag, "_alu_mux"},  {31'd0, bus.alu_mux_sel_out},      32'd0);
        check_val({tag, "_alu_func"}, {26'd0, bus.alu_func_out},         32'd0);
        check_val({tag, "_size"},     {30'd0, bus.data_mem_size_out},    32'd0);
        check_val({tag, "_dmux"},     {31'd0, bus.data_mem_mux_sel_out}, 32'd0);
        check_val({tag, "_taken"},    {31'd0, bus.branch_taken_out},     32'd0);
        check_val({tag, "_illegal"},  {31'd0, bus.illegal_op_out},       32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #2;
        check_idle("reset");
        m_taken = 1'b0;
        m_ill   = 1'b0;
        m_instr = 0;
        m_stall = 0;
        reset   = 1'b1;
    endtask

    // Runs one instruction from its first FETCH cycle; each cycle is checked mid-period.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic br,
                             input logic jmp, input int nwait, input bit glitch, input bit abort);
        int  k;
        bit  has_mem;
        bit  has_wb;
        bit  aborted;
        int  total;
        k = kind_tab[op];
        if (k == K_R && !rfn_ok[fn]) k = K_ILL;
        has_mem = (k == K_LD) || (k == K_ST);
        has_wb  = (k == K_R) || (k == K_IMM) || (k == K_LD);
        total   = FC + 2 + (has_mem ? nwait + 1 : 0) + (has_wb ? 1 : 0);
        aborted = 1'b0;
        for (int c = 0; c < total; c++) begin
            bit   p_dec;
            bit   p_ex;
            bit   p_mem;
            bit   p_wb;
            int   mi;
            logic e_pc;
            p_dec = (c == FC);
            p_ex  = (c == FC + 1);
            mi    = c - (FC + 2);
            p_mem = has_mem && mi >= 0 && mi <= nwait;
            p_wb  = has_wb && (c == total - 1);
            @(negedge clock);
            bus.opcode_in     = p_dec ? op : 6'($urandom);
            bus.func_in       = p_dec ? fn : 6'($urandom);
            bus.alu_branch_in = p_ex ? br  : 1'($urandom);
            bus.alu_jump_in   = p_ex ? jmp : 1'($urandom);
            bus.mem_wait_in   = p_mem ? (mi < nwait) : 1'($urandom);
            #1;
            if (p_ex && k == K_ILL) m_ill = 1'b1;
            e_pc = (p_ex && (k == K_BR || k == K_ILL)) ||
                   (p_mem && k == K_ST && mi == nwait) || p_wb;
            check_val("pc_en",   {31'd0, bus.pc_en_out},       {31'd0, e_pc});
            check_val("rf_we",   {31'd0, bus.regfile_we_out},  {31'd0, p_wb});
            check_val("mem_re",  {31'd0, bus.data_mem_re_out}, {31'd0, p_mem && k == K_LD});
            check_val("mem_we",  {31'd0, bus.data_mem_we_out}, {31'd0, p_mem && k == K_ST});
            check_val("taken",   {31'd0, bus.branch_taken_out}, {31'd0, m_taken});
            check_val("illegal", {31'd0, bus.illegal_op_out},   {31'd0, m_ill});
            if (p_ex && k != K_ILL) begin
                check_val("alu_func", {26'd0, bus.alu_func_out},
                          {26'd0, (k == K_R) ? fn : func_tab[op]});
                check_val("alu_mux", {31'd0, bus.alu_mux_sel_out},
                          {31'd0, k == K_IMM || k == K_LD || k == K_ST});
            end
            if (p_mem) check_val("mem_size", {30'd0, bus.data_mem_size_out}, {30'd0, size_tab[op]});
            if (p_wb) begin
                check_val("inst_mux", {31'd0, bus.inst_mux_sel_out},     {31'd0, k == K_R});
                check_val("wb_dmux",  {31'd0, bus.data_mem_mux_sel_out}, {31'd0, k == K_LD});
            end
            if (e_pc) m_instr++;
            if (p_mem && mi < nwait) m_stall++;
            if (p_ex && k == K_BR) m_taken = (op == 6'h02) ? jmp : br;
            if (glitch && c == 0) begin
                #1 reset = 1'b0;
                #1 reset = 1'b1;
            end
            if (abort && p_mem && mi == nwait - 1) begin
                #1 reset = 1'b0;
                aborted = 1'b1;
                break;
            end
        end
        if (aborted) begin
            @(posedge clock);
            #2;
            check_idle("abort");
            m_taken = 1'b0;
            m_ill   = 1'b0;
            m_instr = 0;
            m_stall = 0;
            reset   = 1'b1;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end

    initial begin
        bus.opcode_in     = 6'h00;
        bus.func_in       = 6'h00;
        bus.alu_branch_in = 1'b0;
        bus.alu_jump_in   = 1'b0;
        bus.mem_wait_in   = 1'b0;
        init_tables();
        do_reset();

        run_instr(6'h00, 6'h20, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        run_instr(6'h23, 6'h00, 1'b0, 1'b0, 3, 1'b0, 1'b0);
        run_instr(6'h28, 6'h00, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        run_instr(6'h04, 6'h00, 1'b1, 1'b0, 0, 1'b0, 1'b0);
        run_instr(6'h05, 6'h00, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        run_instr(6'h02, 6'h00, 1'b0, 1'b1, 0, 1'b1, 1'b0);
        run_instr(6'h3E, 6'h00, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        run_instr(6'h08, 6'h00, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        run_instr(6'h2B, 6'h00, 1'b0, 1'b0, 2, 1'b0, 1'b1);
        run_instr(6'h00, 6'h2A, 1'b0, 1'b0, 0, 1'b0, 1'b0);

        for (int n = 0; n < 250; n++) begin
            logic [5:0] op;
            logic [5:0] fn;
            logic       br;
            logic       jmp;
            int         sel;
            int         nw;
            sel = $urandom_range(0, 9);
            if (sel < 2) op = 6'h00;
            else if (sel < 9) op = legal_ops[$urandom_range(0, 15)];
            else op = 6'($urandom);
            if ($urandom_range(0, 3) == 0) fn = 6'($urandom);
            else fn = 6'(8'h20 + $urandom_range(0, 7));
            br  = 1'($urandom);
            jmp = 1'($urandom);
            if (op == 6'h02) br = 1'b0;
            if (op == 6'h04 || op == 6'h05) jmp = 1'b0;
            nw = $urandom_range(0, 3);
            run_instr(op, fn, br, jmp, nw, $urandom_range(0, 15) == 0,
                      nw > 0 && $urandom_range(0, 19) == 0);
        end

`ifdef CTRL_PERF_COUNTERS_EN
        @(negedge clock);
        check_val("instr_count", bus.instr_count_out, 32'(m_instr));
        check_val("stall_count", bus.stall_count_out, 32'(m_stall));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Multi-cycle control FSM that sequences the single-issue MIPS datapath.
- Consumes opcode, funct and the ALU branch/jump flags from the datapath.
- Drives every datapath control input: PC enable, mux selects, register-file write, ALU function, data-memory strobes and size.
- One instruction is in flight at a time. Memory-phase stalls are supported for serial-mapped accesses.

Parameters:
- FETCH_CYCLES, 1: cycles spent in FETCH for instruction-ROM read latency; legal range 1..4.
- DATA_SIZE_W, 2: width of data_mem_size_out.

Ports:
- clock  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low; 0 sampled at a rising edge resets the block.
- opcode_in  in  6  instruction[31:26] from the datapath.
- func_in  in  6  instruction[5:0] from the datapath.
- alu_branch_in  in  1  ALU branch-condition-true flag.
- alu_jump_in  in  1  ALU jump flag.
- mem_wait_in  in  1  1 = data memory/serial not ready; hold the MEM state.
- pc_en_out  out  1  one-cycle PC advance pulse.
- inst_mux_sel_out  out  1  write-register select: 0 = rt, 1 = rd.
- regfile_we_out  out  1  register-file write strobe.
- alu_mux_sel_out  out  1  ALU B operand: 0 = rt data, 1 = sign-extended immediate.
- alu_func_out  out  6  ALU function code.
- data_mem_re_out  out  1  data-memory read strobe.
- data_mem_we_out  out  1  data-memory write strobe.
- data_mem_size_out  out  DATA_SIZE_W  access size: 00 = byte, 01 = half, 11 = word.
- data_mem_mux_sel_out  out  1  writeback source: 0 = ALU, 1 = memory.
- branch_taken_out  out  1  registered; 1 for the last instruction whose branch or jump was taken.
- illegal_op_out  out  1  sticky; set on an undecodable opcode or funct.

Behaviour:
- Reset (reset == 0 at a clock edge):
  - State goes to FETCH and the fetch counter clears.
  - All outputs go to 0, including branch_taken_out and illegal_op_out.
  - Reset during any state, including a MEM stall, aborts the instruction; no strobe is asserted in the reset cycle.
- States: FETCH -> DECODE -> EXEC -> {MEM, WB, FETCH}; MEM -> {WB, FETCH}; WB -> FETCH.
- FETCH: held for FETCH_CYCLES cycles; all strobes 0.
- DECODE: one cycle. Opcode and funct are registered into the decoded control word; the combinational inputs are not used again.
- EXEC:
  - alu_func_out and alu_mux_sel_out are driven from the decoded word.
  - Branch/jump (BEQ 0x04, BNE 0x05, J 0x02): alu_branch_in or alu_jump_in is sampled and loaded into branch_taken_out; pc_en_out = 1; next state FETCH.
  - Loads and stores go to MEM. All others go to WB.
- MEM:
  - data_mem_re_out (LB 0x20, LH 0x21, LW 0x23) or data_mem_we_out (SB 0x28, SH 0x29, SW 0x2B) is held while mem_wait_in = 1.
  - Exit occurs on the first cycle with mem_wait_in = 0. Loads go to WB.
  - Stores assert pc_en_out in that exit cycle and go to FETCH.
  - A write strobe is never repeated after that exit cycle.
- WB:
  - regfile_we_out = 1 and pc_en_out = 1 for one cycle.
  - inst_mux_sel_out = 1 only for R-type (opcode 0x00).
  - data_mem_mux_sel_out = 1 only for loads.
- Latency with FETCH_CYCLES = 1 and no waits:
  - R-type and immediate ALU: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch/jump: 3 cycles.
- ALU function mapping:
  - R-type: alu_func_out = func_in.
  - ADDI 0x08 -> 0x20; ADDIU 0x09 -> 0x21; SLTI 0x0A -> 0x2A.
  - ANDI 0x0C -> 0x24; ORI 0x0D -> 0x25; XORI 0x0E -> 0x26; LUI 0x0F -> 0x3F.
  - Loads/stores -> 0x21. BEQ -> 0x30; BNE -> 0x31; J -> 0x32.
- Illegal opcode or R-type funct not in {0x20-0x27, 0x2A, 0x2B, 0x00, 0x02, 0x03}:
  - Treated as a NOP: EXEC -> FETCH with pc_en_out = 1 and no writes.
  - illegal_op_out is set and stays set until reset.
- pc_en_out is asserted exactly once per instruction.

Optional Feature:
- Macro: CTRL_PERF_COUNTERS_EN.
- When defined: adds outputs instr_count_out[31:0] and stall_count_out[31:0].
  - instr_count_out increments on each pc_en_out pulse.
  - stall_count_out increments on each MEM cycle with mem_wait_in = 1.
  - Both wrap modulo 2^32 and clear on reset.
- When undefined: neither port exists and no counter logic is present.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - the state enum;
  - the opcode localparams;
  - the ALU function localparams, including BEQ/BNE/J 0x30/0x31/0x32;
  - the size encodings;
  - the decoded control-word struct.
- Sub-module mips_ctrl_decode: a purely combinational map from opcode/funct to the control word plus an illegal flag. The FSM lives in the top.

Test Plan:
- R-type ADD (opcode 0x00, func 0x20): regfile_we_out = 1, inst_mux_sel_out = 1 and pc_en_out = 1 in cycle 4 only; alu_func_out = 0x20 in EXEC.
- LW (0x23) with mem_wait_in high for 3 MEM cycles: data_mem_re_out held for 4 cycles, size = 11; WB in cycle 8 with data_mem_mux_sel_out = 1.
- SB (0x28): data_mem_we_out for 1 cycle, size = 00, pc_en_out in the same cycle, regfile_we_out never asserted.
- BEQ with alu_branch_in = 1: pc_en_out in cycle 3 and branch_taken_out = 1. A following BNE with flag 0 clears branch_taken_out.
- Opcode 0x3E: illegal_op_out rises and stays set; no write strobes; pc_en_out in cycle 3.
- reset driven to 0 during a stalled MEM store: next cycle data_mem_we_out = 0, state FETCH, all outputs 0. An async glitch of reset between edges has no effect.
